// File: rtl/niosii_system_sysid_pkg.sv
// Shared types and constants for the sysid checker and its read timer.
package niosii_system_sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_CMP,
    S_DONE
  } state_t;

  typedef logic [31:0] word_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/niosii_system_avm_read_timer.sv
// Stall counter for one Avalon read; expired pulses on the stalled cycle
// that brings the count to TIMEOUT_CYCLES.
module niosii_system_avm_read_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic stalled,
  input  logic clear,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] cnt_inc;

  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (stalled) begin
      cnt_d = cnt_inc;
    end
  end

  // Fire on the edge that reaches the limit so the read drops right away.
  assign expired = stalled && !clear && (cnt_inc == LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Reads sysid ID/timestamp over Avalon-MM and flags a mismatched image.
// Optional periodic re-check enabled by defining SYSID_CHECK_PERIODIC_EN.
//
// state   | meaning
// S_IDLE  | waiting for start / auto-start / periodic trigger
// S_RD_ID | read sysid address 0 (ID word)
// S_RD_TS | read sysid address 1 (timestamp word)
// S_CMP   | register equality results
// S_DONE  | done asserted, busy released
module niosii_system_sysid_checker
  import niosii_system_sysid_pkg::*;
#(
  parameter word_t       EXPECTED_ID    = 32'h0000_0000,
  parameter word_t       EXPECTED_TS    = 32'h56A2_81EC,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
`ifdef SYSID_CHECK_PERIODIC_EN
  ,
  parameter int unsigned RECHECK_PERIOD = 50_000_000
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  state_t state_q, state_d;
  logic   auto_q, auto_d;
  logic   avm_read_q, avm_read_d;
  logic   avm_address_q, avm_address_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   id_ok_q, id_ok_d;
  logic   ts_ok_q, ts_ok_d;
  logic   timeout_q, timeout_d;
  word_t  captured_id_q, captured_id_d;
  word_t  captured_ts_q, captured_ts_d;

  logic   rd_done;
  logic   stalled;
  logic   expired;
  logic   periodic_start;
  logic   launch;

  assign rd_done = avm_read_q && !avm_waitrequest;
  assign stalled = avm_read_q && avm_waitrequest;

  niosii_system_avm_read_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .stalled(stalled),
    .clear  (!stalled),
    .expired(expired)
  );

`ifdef SYSID_CHECK_PERIODIC_EN
  logic [31:0] period_q, period_d;

  always_comb begin
    period_d       = period_q;
    periodic_start = 1'b0;
    if (start || state_q != S_IDLE) begin
      period_d = '0;
    end else if (period_q == 32'(RECHECK_PERIOD)) begin
      periodic_start = 1'b1;
      period_d       = '0;
    end else begin
      period_d = period_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end
`else
  assign periodic_start = 1'b0;
`endif

  assign launch = start || auto_q || periodic_start;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      auto_q        <= AUTO_START;
      avm_read_q    <= 1'b0;
      avm_address_q <= SYSID_ADDR_ID;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
      captured_id_q <= '0;
      captured_ts_q <= '0;
    end else begin
      state_q       <= state_d;
      auto_q        <= auto_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_q     <= timeout_d;
      captured_id_q <= captured_id_d;
      captured_ts_q <= captured_ts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    auto_d  = auto_q && (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (launch) state_d = S_RD_ID;
      S_RD_ID: begin
        if (expired) state_d = S_DONE;
        else if (rd_done) state_d = S_RD_TS;
      end
      S_RD_TS: begin
        if (expired) state_d = S_DONE;
        else if (rd_done) state_d = S_CMP;
      end
      S_CMP:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    avm_read_d    = (state_d == S_RD_ID) || (state_d == S_RD_TS);
    avm_address_d = (state_d == S_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy_d        = busy_q;
    done_d        = done_q;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_d     = timeout_q;
    captured_id_d = captured_id_q;
    captured_ts_d = captured_ts_q;

    if (state_q == S_IDLE && state_d == S_RD_ID) begin
      busy_d    = 1'b1;
      done_d    = 1'b0;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      timeout_d = 1'b0;
    end
    if (state_q == S_RD_ID && rd_done) captured_id_d = avm_readdata;
    if (state_q == S_RD_TS && rd_done) captured_ts_d = avm_readdata;
    if (state_q == S_CMP) begin
      id_ok_d = (captured_id_q == EXPECTED_ID);
      ts_ok_d = (captured_ts_q == EXPECTED_TS);
    end
    if (expired) begin
      timeout_d = 1'b1;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
    end
    if (state_d == S_DONE) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign captured_id = captured_id_q;
  assign captured_ts = captured_ts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench for the sysid checker with a simple sysid slave model.
module tb_niosii_system_sysid_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] captured_id, captured_ts;

  logic [31:0] id_word;
  logic [31:0] ts_word;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign avm_readdata = avm_address ? ts_word : id_word;

  niosii_system_sysid_checker #(
    .EXPECTED_ID   (32'h0000_0000),
    .EXPECTED_TS   (32'h56A2_81EC),
    .TIMEOUT_CYCLES(8),
    .AUTO_START    (1'b1)
`ifdef SYSID_CHECK_PERIODIC_EN
    ,
    .RECHECK_PERIOD(20)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .captured_id    (captured_id),
    .captured_ts    (captured_ts)
  );

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        exp_id_ok;
    logic        exp_ts_ok;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (!done && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"}, avm_read, 0);
    chk({tag, "_addr"}, avm_address, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_flags"}, {id_ok, ts_ok, timeout}, 0);
    chk({tag, "_cid"}, captured_id, 0);
    chk({tag, "_cts"}, captured_ts, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int rc;

    vecs[0] = '{32'h0000_0000, 32'h56A2_81EC, 1'b1, 1'b1};
    vecs[1] = '{32'h0000_0000, 32'h56A2_81ED, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0001, 32'h56A2_81EC, 1'b0, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'hD6A2_81EC, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h56A2_81EC, 1'b1, 1'b1};

    reset           = 1'b1;
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    id_word         = 32'h0000_0000;
    ts_word         = 32'h56A2_81EC;
    tick();
    tick();
    chk_all_zero("rst");

    // auto-start after release: cycle 0 idle, reads on 1 and 2, done on 4
    reset = 1'b0;
    chk("auto_c0_read", avm_read, 0);
    tick();
    chk("auto_c1_read", {avm_read, avm_address}, 2'b10);
    chk("auto_c1_busy", busy, 1);
    tick();
    chk("auto_c2_read", {avm_read, avm_address}, 2'b11);
    tick();
    chk("auto_c3_read", avm_read, 0);
    chk("auto_c3_done", done, 0);
    tick();
    chk("auto_c4_done", {done, busy}, 2'b10);
    chk("auto_flags", {id_ok, ts_ok, timeout}, 3'b110);
    chk("auto_cts", captured_ts, 32'h56A2_81EC);
    tick();
    tick();

    for (int i = 0; i < 6; i++) begin
      id_word = vecs[i].id;
      ts_word = vecs[i].ts;
      pulse_start();
      chk("vec_done_clr", done, 0);
      wait_done(20, cyc);
      chk("vec_latency", cyc + 1, 4);
      chk("vec_done", done, 1);
      chk("vec_id_ok", id_ok, vecs[i].exp_id_ok);
      chk("vec_ts_ok", ts_ok, vecs[i].exp_ts_ok);
      chk("vec_timeout", timeout, 0);
      chk("vec_cid", captured_id, vecs[i].id);
      chk("vec_cts", captured_ts, vecs[i].ts);
      tick();
    end

    // start during the S_DONE cycle is dropped
    pulse_start();
    wait_done(20, cyc);
    pulse_start();
    rc = 0;
    for (int k = 0; k < 5; k++) begin
      rc += int'(avm_read);
      tick();
    end
    chk("drop_start_reads", rc, 0);
    chk("drop_start_done", done, 1);

    // ID read stalled for 3 cycles
    avm_waitrequest = 1'b1;
    pulse_start();
    chk("stall_n1", {avm_read, avm_address}, 2'b10);
    tick();
    chk("stall_n2", {avm_read, avm_address}, 2'b10);
    tick();
    chk("stall_n3", {avm_read, avm_address}, 2'b10);
    tick();
    avm_waitrequest = 1'b0;
    chk("stall_n4", {avm_read, avm_address}, 2'b10);
    tick();
    chk("stall_n5", {avm_read, avm_address}, 2'b11);
    tick();
    chk("stall_n6_done", done, 0);
    tick();
    chk("stall_n7_done", done, 1);
    chk("stall_flags", {id_ok, ts_ok, timeout}, 3'b110);
    tick();

    // timestamp read stuck on waitrequest; ID still captured
    id_word = 32'h0000_0000;
    ts_word = 32'h1111_2222;
    pulse_start();
    tick();
    avm_waitrequest = 1'b1;
    rc = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) break;
      rc += int'(avm_read);
      tick();
    end
    chk("to_read_cycles", rc, 8);
    chk("to_done", {done, busy, avm_read}, 3'b100);
    chk("to_flags", {id_ok, ts_ok, timeout}, 3'b001);
    chk("to_cid", captured_id, 32'h0000_0000);
    chk("to_cts_kept", captured_ts, 32'h56A2_81EC);
    avm_waitrequest = 1'b0;
    ts_word = 32'h56A2_81EC;
    tick();

    // second start while busy is ignored
    pulse_start();
    rc = int'(avm_read);
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      rc += int'(avm_read);
      tick();
    end
    chk("busy_start_reads", rc, 2);
    chk("busy_start_done", done, 1);
    chk("busy_start_flags", {id_ok, ts_ok, timeout}, 3'b110);

    // reset during S_RD_TS, then auto-start relaunch
    id_word = 32'h0000_1234;
    pulse_start();
    tick();
    chk("mid_rd_ts", {avm_read, avm_address}, 2'b11);
    chk("mid_cid", captured_id, 32'h0000_1234);
    reset = 1'b1;
    tick();
    chk_all_zero("mid_rst");
    id_word = 32'h0000_0000;
    reset = 1'b0;
    wait_done(20, cyc);
    chk("relaunch_latency", cyc, 4);
    chk("relaunch_flags", {done, id_ok, ts_ok, timeout}, 4'b1110);

`ifdef SYSID_CHECK_PERIODIC_EN
    begin
      int   rises = 0;
      int   t1 = 0;
      int   t2 = 0;
      logic prev;
      rc   = 0;
      prev = done;
      for (int k = 0; k < 200 && rises < 2; k++) begin
        tick();
        if (rises == 1 && avm_read) rc++;
        if (done && !prev) begin
          rises++;
          if (rises == 1) t1 = k;
          else t2 = k;
        end
        prev = done;
      end
      chk("per_rises", rises, 2);
      chk("per_spacing", t2 - t1, 25);
      chk("per_reads", rc, 2);
    end
`else
    rc = 0;
    for (int k = 0; k < 40; k++) begin
      rc += int'(avm_read);
      tick();
    end
    chk("no_recheck_reads", rc, 0);
    chk("no_recheck_done", done, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
